sad_min_tree: RTL

SAD_MIN_TREE -- requirements
Module: sad_min_tree

---
 rtl/sad_min_tree_pkg.sv | 22 ++
 rtl/sad_min8.sv | 27 ++
 rtl/sad_min_tree.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sad_min_tree_pkg.sv
// Shared SAD search types and default sizes.
// Used by the PE array, the search controller and sad_min_tree.
package sad_min_tree_pkg;
   localparam int DEF_NUM_CAND = 32;
   localparam int DEF_NUM_PIX  = 32;
   localparam int DEF_PIX_W    = 8;
   localparam int DEF_ROWS     = 8;
   localparam int DEF_SAD_W    = 16;
   localparam int DEF_IDX_W    = 7;

   typedef struct packed {
      logic [DEF_SAD_W-1:0] sad;
      logic [DEF_IDX_W-1:0] idx;
   } sad_idx_t;

   // Per-group control captured on the group's first beat.
   typedef struct packed {
      logic                 start;
      logic                 last;
      logic [DEF_IDX_W-1:0] base;
   } grp_meta_t;
endpackage

// File: rtl/sad_min8.sv
// Combinational N-input minimum, lowest index wins on ties.
// Ports: i_sad (N packed values), o_min (minimum), o_idx (its index).
module sad_min8
   import sad_min_tree_pkg::*;
#(
   parameter int N  = 8,
   parameter int W  = DEF_SAD_W,
   parameter int IW = $clog2(N)
)(
   input  logic [N*W-1:0] i_sad,
   output logic [W-1:0]   o_min,
   output logic [IW-1:0]  o_idx
);

   // Strict less-than while scanning upward keeps the lowest index on ties.
   always_comb begin
      o_min = i_sad[W-1:0];
      o_idx = '0;
      for (int i = 1; i < N; i++) begin
         if (i_sad[i*W +: W] < o_min) begin
            o_min = i_sad[i*W +: W];
            o_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/sad_min_tree.sv
// Row-beat SAD accumulation and pipelined minimum search over candidates.
// Ports: clk/rst; i_abs_* row beats with search control; o_result_valid,
// o_best_sad, o_best_idx final search result; o_proto_err restart pulse.
module sad_min_tree
   import sad_min_tree_pkg::*;
#(
   parameter int NUM_CAND = DEF_NUM_CAND,
   parameter int NUM_PIX  = DEF_NUM_PIX,
   parameter int PIX_W    = DEF_PIX_W,
   parameter int ROWS     = DEF_ROWS,
   parameter int SAD_W    = DEF_SAD_W,
   parameter int IDX_W    = DEF_IDX_W
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_abs_valid,
   input  logic [NUM_CAND*NUM_PIX*PIX_W-1:0] i_abs_in,
   input  logic                              i_srch_start,
   input  logic                              i_srch_last,
   input  logic [IDX_W-1:0]                  i_cand_base,
   output logic                              o_result_valid,
   output logic [SAD_W-1:0]                  o_best_sad,
   output logic [IDX_W-1:0]                  o_best_idx,
   output logic                              o_proto_err
);

   localparam int NQ  = NUM_PIX / 8;
   localparam int NG  = NUM_CAND / 8;
   localparam int PW  = PIX_W + 3;
   localparam int RW  = PIX_W + 5;
   localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
   localparam int LW  = GW + 3;

   logic [RCW-1:0]  r_row, w_row;
   logic            r_started, w_first, w_lastrow, w_restart;
   grp_meta_t       r_meta, w_meta;
   logic [PW-1:0]   w_part [NUM_CAND][NQ];
   logic [PW-1:0]   r_part [NUM_CAND][NQ];
   logic            r_s1_vld, r_s1_first, r_s1_last;
   grp_meta_t       r_s1_meta;
   logic [RW-1:0]   w_rsum [NUM_CAND];
   logic [SAD_W-1:0] r_acc [NUM_CAND];
   logic            r_s2_done;
   grp_meta_t       r_s2_meta;
   logic [NUM_CAND*SAD_W-1:0] r_grp;
   logic            r_g_vld;
   grp_meta_t       r_g_meta;
   logic [SAD_W-1:0] w_q_min [NG];
   logic [2:0]      w_q_idx [NG];
   logic [NG*SAD_W-1:0] r_m1_sad;
   logic [2:0]      r_m1_idx [NG];
   logic            r_m1_vld;
   grp_meta_t       r_m1_meta;
   logic [SAD_W-1:0] w_g_min;
   logic [GW-1:0]   w_g_q;
   logic [SAD_W-1:0] r_m2_sad;
   logic [LW-1:0]   r_m2_idx;
   logic            r_m2_vld;
   grp_meta_t       r_m2_meta;
   sad_idx_t        r_best, r_out, w_new;
   logic            r_res_vld, r_proto;

   // A start on a non-zero row abandons the partial group and
   // makes this beat row 0 of a fresh search.
   always_comb begin
      w_restart = i_abs_valid && i_srch_start && (r_row != '0);
      w_first   = (r_row == '0) || i_srch_start;
      w_row     = i_srch_start ? '0 : r_row;
      w_lastrow = (w_row == RCW'(ROWS - 1));
      w_meta    = r_meta;
      if (w_first) begin
         w_meta.start = i_srch_start || !r_started;
         w_meta.last  = i_srch_last;
         w_meta.base  = i_cand_base;
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CAND; c++) begin
         for (int q = 0; q < NQ; q++) begin
            w_part[c][q] = '0;
            for (int p = 0; p < 8; p++) begin
               w_part[c][q] = w_part[c][q] + PW'(
                  i_abs_in[((c*NUM_PIX)+(q*8)+p)*PIX_W +: PIX_W]);
            end
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CAND; c++) begin
         w_rsum[c] = '0;
         for (int q = 0; q < NQ; q++) begin
            w_rsum[c] = w_rsum[c] + RW'(r_part[c][q]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row      <= '0;
         r_started  <= 1'b0;
         r_meta     <= '0;
         r_proto    <= 1'b0;
         r_s1_vld   <= 1'b0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_meta  <= '0;
         for (int c = 0; c < NUM_CAND; c++) begin
            for (int q = 0; q < NQ; q++) begin
               r_part[c][q] <= '0;
            end
         end
      end else begin
         r_s1_vld <= i_abs_valid;
         r_proto  <= w_restart;
         if (i_abs_valid) begin
            r_row      <= w_lastrow ? '0 : w_row + 1'b1;
            r_started  <= 1'b1;
            r_meta     <= w_meta;
            r_s1_first <= w_first;
            r_s1_last  <= w_lastrow;
            r_s1_meta  <= w_meta;
            r_part     <= w_part;
         end
      end
   end

   for (genvar g = 0; g < NG; g++) begin : g_m1
      sad_min8 #(.N(8), .W(SAD_W)) u_min_q (
         .i_sad (r_grp[g*8*SAD_W +: 8*SAD_W]),
         .o_min (w_q_min[g]),
         .o_idx (w_q_idx[g])
      );
   end

   sad_min8 #(.N(NG), .W(SAD_W)) u_min_grp (
      .i_sad (r_m1_sad),
      .o_min (w_g_min),
      .o_idx (w_g_q)
   );

   // Running best: a search's first group loads, later groups
   // replace only on a strictly smaller SAD.
   always_comb begin
      w_new.sad = r_m2_sad;
      w_new.idx = r_m2_meta.base + IDX_W'(r_m2_idx);
      if (!(r_m2_meta.start || (r_m2_sad < r_best.sad))) begin
         w_new = r_best;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_done <= 1'b0;
         r_s2_meta <= '0;
         r_g_vld   <= 1'b0;
         r_g_meta  <= '0;
         r_grp     <= '0;
         r_m1_vld  <= 1'b0;
         r_m1_meta <= '0;
         r_m1_sad  <= '0;
         r_m2_vld  <= 1'b0;
         r_m2_meta <= '0;
         r_m2_sad  <= '0;
         r_m2_idx  <= '0;
         r_best    <= '0;
         r_out     <= '0;
         r_res_vld <= 1'b0;
         for (int c = 0; c < NUM_CAND; c++) begin
            r_acc[c] <= '0;
         end
         for (int g = 0; g < NG; g++) begin
            r_m1_idx[g] <= '0;
         end
      end else begin
         r_s2_done <= r_s1_vld && r_s1_last;
         r_s2_meta <= r_s1_meta;
         if (r_s1_vld) begin
            for (int c = 0; c < NUM_CAND; c++) begin
               r_acc[c] <= (r_s1_first ? '0 : r_acc[c])
                           + SAD_W'(w_rsum[c]);
            end
         end
         // Snapshot frees the accumulators for a back-to-back group.
         r_g_vld  <= r_s2_done;
         r_g_meta <= r_s2_meta;
         if (r_s2_done) begin
            for (int c = 0; c < NUM_CAND; c++) begin
               r_grp[c*SAD_W +: SAD_W] <= r_acc[c];
            end
         end
         r_m1_vld  <= r_g_vld;
         r_m1_meta <= r_g_meta;
         for (int g = 0; g < NG; g++) begin
            r_m1_sad[g*SAD_W +: SAD_W] <= w_q_min[g];
            r_m1_idx[g]                <= w_q_idx[g];
         end
         r_m2_vld  <= r_m1_vld;
         r_m2_meta <= r_m1_meta;
         r_m2_sad  <= w_g_min;
         r_m2_idx  <= {w_g_q, r_m1_idx[w_g_q]};
         r_res_vld <= r_m2_vld && r_m2_meta.last;
         if (r_m2_vld) begin
            r_best <= w_new;
            if (r_m2_meta.last) begin
               r_out <= w_new;
            end
         end
      end
   end

   assign o_result_valid = r_res_vld;
   assign o_best_sad     = r_out.sad;
   assign o_best_idx     = r_out.idx;
   assign o_proto_err    = r_proto;

endmodule
